// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - payout request, coin-eject handshake and status bundle for change_dispenser
interface change_dispenser_if #(
   parameter int PRICE_WIDTH = 16,
   parameter int COUNT_WIDTH = 8
);
   logic [PRICE_WIDTH-1:0] change_amount;
   logic                   change_ready;
   logic                   eject_ack;
   logic                   refill_en;
   logic [3:0]             refill_denom;
   logic [COUNT_WIDTH-1:0] refill_count;
   logic [8:0]             coin_eject;
   logic                   busy;
   logic                   payout_done;
   logic                   short_flag;
   logic [PRICE_WIDTH-1:0] shortfall;
   logic                   fault;
   logic [PRICE_WIDTH-1:0] remaining;

   modport master (
      output change_amount, change_ready, eject_ack, refill_en, refill_denom, refill_count,
      input  coin_eject, busy, payout_done, short_flag, shortfall, fault, remaining
   );

   modport slave (
      input  change_amount, change_ready, eject_ack, refill_en, refill_denom, refill_count,
      output coin_eject, busy, payout_done, short_flag, shortfall, fault, remaining
   );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy largest-coin-first payout engine; stock counters enabled by CHANGE_STOCK_EN
module change_dispenser #(
   parameter int PRICE_WIDTH = 16,
   parameter int COUNT_WIDTH = 8,
   parameter int INIT_STOCK  = 20,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   change_dispenser_if.slave  bus
);
   localparam int WAIT_WIDTH = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic [PRICE_WIDTH-1:0] remaining_q, remaining_d;
   logic [PRICE_WIDTH-1:0] shortfall_q, shortfall_d;
   logic [3:0]             denom_q, denom_d;
   logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
   logic                   short_q, short_d;
   logic                   fault_q, fault_d;

   logic [8:0] avail;
   logic [3:0] pick;
   logic       pick_ok;
   logic       start;
   logic       timeout;

   function automatic logic [PRICE_WIDTH-1:0] coin_value(input logic [3:0] d);
      case (d)
         4'd0:    coin_value = PRICE_WIDTH'(1);
         4'd1:    coin_value = PRICE_WIDTH'(2);
         4'd2:    coin_value = PRICE_WIDTH'(5);
         4'd3:    coin_value = PRICE_WIDTH'(10);
         4'd4:    coin_value = PRICE_WIDTH'(20);
         4'd5:    coin_value = PRICE_WIDTH'(50);
         4'd6:    coin_value = PRICE_WIDTH'(100);
         4'd7:    coin_value = PRICE_WIDTH'(500);
         4'd8:    coin_value = PRICE_WIDTH'(2000);
         default: coin_value = '0;
      endcase
   endfunction

   // Only a fresh 0->1 edge of change_ready starts a payout, and never once faulted.
   assign start   = bus.change_ready && !ready_q && !fault_q;
   assign timeout = (wait_q == WAIT_WIDTH'(ACK_TIMEOUT - 1));

`ifdef CHANGE_STOCK_EN
   logic [COUNT_WIDTH-1:0] stock_q [9];
   logic [COUNT_WIDTH-1:0] stock_d [9];
   logic [COUNT_WIDTH:0]   sum     [9];
   logic                   dec;

   assign dec = (state_q == S_EJECT) && bus.eject_ack;

   // Stock update: refill and an acked coin may hit the same counter; result saturates.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         sum[i] = {1'b0, stock_q[i]};
         if (bus.refill_en && bus.refill_denom == 4'(i))
            sum[i] = sum[i] + {1'b0, bus.refill_count};
         if (dec && denom_q == 4'(i))
            sum[i] = sum[i] - (COUNT_WIDTH + 1)'(1);
         stock_d[i] = sum[i][COUNT_WIDTH] ? '1 : sum[i][COUNT_WIDTH-1:0];
         avail[i]   = (stock_q[i] != '0);
      end
   end

   // Stock counters restart full on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) stock_q[i] <= COUNT_WIDTH'(INIT_STOCK);
      end else begin
         stock_q <= stock_d;
      end
   end
`else
   logic unused_refill;
   assign unused_refill = ^{bus.refill_en, bus.refill_denom, bus.refill_count};
   assign avail         = '1;
`endif

   // Highest available denomination that still fits into the remaining amount.
   always_comb begin
      pick    = 4'd0;
      pick_ok = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (avail[i] && coin_value(4'(i)) <= remaining_q) begin
            pick    = 4'(i);
            pick_ok = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; an ack on the last allowed cycle wins over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_SELECT;
         S_SELECT: state_d = (remaining_q != '0 && pick_ok) ? S_EJECT : S_DONE;
         S_EJECT: begin
            if (bus.eject_ack)  state_d = S_SELECT;
            else if (timeout)   state_d = S_DONE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: capture, coin selection, payout accounting, shortfall and fault.
   always_comb begin
      ready_d     = bus.change_ready;
      remaining_d = remaining_q;
      shortfall_d = shortfall_q;
      denom_d     = denom_q;
      wait_d      = wait_q;
      short_d     = short_q;
      fault_d     = fault_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = bus.change_amount;
               short_d     = 1'b0;
               shortfall_d = '0;
            end
         end
         S_SELECT: begin
            wait_d = '0;
            if (remaining_q != '0) begin
               if (pick_ok) begin
                  denom_d = pick;
               end else begin
                  shortfall_d = remaining_q;
                  short_d     = 1'b1;
               end
            end
         end
         S_EJECT: begin
            if (bus.eject_ack) begin
               remaining_d = remaining_q - coin_value(denom_q);
            end else if (timeout) begin
               fault_d     = 1'b1;
               shortfall_d = remaining_q;
               short_d     = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         remaining_q <= '0;
         shortfall_q <= '0;
         denom_q     <= '0;
         wait_q      <= '0;
         short_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         ready_q     <= ready_d;
         remaining_q <= remaining_d;
         shortfall_q <= shortfall_d;
         denom_q     <= denom_d;
         wait_q      <= wait_d;
         short_q     <= short_d;
         fault_q     <= fault_d;
      end
   end

   // Outputs decoded from state so coin_eject falls with the asynchronous reset.
   always_comb begin
      bus.coin_eject  = (state_q == S_EJECT) ? (9'd1 << denom_q) : 9'd0;
      bus.busy        = (state_q == S_SELECT) || (state_q == S_EJECT);
      bus.payout_done = (state_q == S_DONE);
      bus.short_flag  = short_q;
      bus.shortfall   = shortfall_q;
      bus.fault       = fault_q;
      bus.remaining   = remaining_q;
   end
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized and directed bench for change_dispenser against a greedy payout model
module tb_change_dispenser;
   localparam int PW  = 16;
   localparam int CW  = 8;
   localparam int TMO = 255;
   localparam int unsigned VALS [9] = '{1, 2, 5, 10, 20, 50, 100, 500, 2000};
`ifdef CHANGE_STOCK_EN
   localparam bit STOCK_ON = 1'b1;
`else
   localparam bit STOCK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int unsigned m_stock [9];
   int unsigned exp_q [$];
   int unsigned exp_short;

   bit          ack_refill_en = 1'b0;
   int unsigned ack_refill_denom;
   int unsigned ack_refill_count;

   change_dispenser_if #(.PRICE_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

   change_dispenser #(
      .PRICE_WIDTH(PW), .COUNT_WIDTH(CW), .INIT_STOCK(20), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned onehot_idx(input logic [8:0] v);
      int unsigned r = 0;
      for (int i = 8; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   // Greedy payout from the coin table and the model's stock.
   function automatic void model_pay(input int unsigned amt);
      int unsigned rem = amt;
      bit found = 1'b1;
      exp_q.delete();
      while (rem > 0 && found) begin
         found = 1'b0;
         for (int d = 8; d >= 0 && !found; d--) begin
            if (VALS[d] <= rem && (!STOCK_ON || m_stock[d] > 0)) begin
               exp_q.push_back(VALS[d]);
               rem -= VALS[d];
               if (STOCK_ON) m_stock[d]--;
               found = 1'b1;
            end
         end
      end
      exp_short = rem;
   endfunction

   function automatic void model_refill(input int unsigned d, input int unsigned c);
      if (STOCK_ON && d < 9) m_stock[d] = (m_stock[d] + c > 255) ? 255 : m_stock[d] + c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) m_stock[i] = 20;
   endtask

   task automatic check_stock(input string tag);
`ifdef CHANGE_STOCK_EN
      for (int i = 0; i < 9; i++) check(tag, dut.stock_q[i], m_stock[i]);
`else
      checks = checks + 0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.change_ready = 1'b0;
      bus.eject_ack    = 1'b0;
      bus.refill_en    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_refill(input int unsigned d, input int unsigned c);
      @(negedge clk);
      bus.refill_en    = 1'b1;
      bus.refill_denom = 4'(d);
      bus.refill_count = 8'(c);
      @(negedge clk);
      bus.refill_en = 1'b0;
      model_refill(d, c);
   endtask

   task automatic run_payout(input int unsigned amt, input int unsigned dly);
      int unsigned got [$];
      int          first_cyc = -1;
      bit          done_seen = 1'b0;
      int unsigned wait_cnt = 0;
      int unsigned n;
      model_pay(amt);
      bus.change_ready = 1'b0;
      @(negedge clk);
      bus.change_amount = PW'(amt);
      bus.change_ready  = 1'b1;
      for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
         @(negedge clk);
         bus.eject_ack = 1'b0;
         bus.refill_en = 1'b0;
         if (cyc == 0) check("busy_after_capture", bus.busy, 1);
         if (bus.payout_done) begin
            done_seen = 1'b1;
            check("busy_at_done", bus.busy, 0);
         end else if (bus.coin_eject != 9'd0) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (wait_cnt == dly) begin
               check("eject_onehot", $onehot(bus.coin_eject), 1);
               got.push_back(VALS[onehot_idx(bus.coin_eject)]);
               bus.eject_ack = 1'b1;
               wait_cnt = 0;
               if (ack_refill_en) begin
                  bus.refill_en    = 1'b1;
                  bus.refill_denom = 4'(ack_refill_denom);
                  bus.refill_count = 8'(ack_refill_count);
                  model_refill(ack_refill_denom, ack_refill_count);
                  ack_refill_en = 1'b0;
               end
            end else begin
               wait_cnt++;
            end
         end
      end
      check("payout_done_seen", done_seen, 1);
      if (exp_q.size() > 0) check("first_eject_latency", first_cyc, 1);
      check("coin_count", got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < int'(n); i++) check("coin_value", got[i], exp_q[i]);
      check("remaining", bus.remaining, exp_short);
      check("short_flag", bus.short_flag, (exp_short != 0));
      check("shortfall", bus.shortfall, exp_short);
   endtask

   initial begin
      int unsigned ej;
      bit          done_seen;
      bit          quiet;
      bus.change_amount = '0;
      bus.change_ready  = 1'b0;
      bus.eject_ack     = 1'b0;
      bus.refill_en     = 1'b0;
      bus.refill_denom  = '0;
      bus.refill_count  = '0;
      model_reset();

      // reset state
      #1;
      check("rst_coin_eject", bus.coin_eject, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.payout_done, 0);
      check("rst_short", bus.short_flag, 0);
      check("rst_shortfall", bus.shortfall, 0);
      check("rst_fault", bus.fault, 0);
      check("rst_remaining", bus.remaining, 0);
      check_stock("rst_stock");
      @(negedge clk);
      rst_n = 1'b1;

      // 87 with ack one cycle after each eject
      run_payout(87, 1);
      check_stock("stock_after_87");

      // zero amount: no ejects, no short
      run_payout(0, 0);

      // level held high must not restart
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.busy || bus.coin_eject != 0) quiet = 1'b0;
      end
      check("held_level_no_restart", quiet, 1);

      // random payouts
      for (int k = 0; k < 8; k++) run_payout($urandom_range(0, 400), $urandom_range(0, 2));
      check_stock("stock_after_random");

      // refill of denom 3 on the ack cycle of a 10
      do_reset();
      ack_refill_en    = 1'b1;
      ack_refill_denom = 3;
      ack_refill_count = 5;
      run_payout(10, 0);
      check_stock("stock_refill_on_ack");

      // saturation and ignored out-of-range denomination
      do_refill(6, 230);
      do_refill(6, 10);
      do_refill(12, 7);
      check_stock("stock_saturate");

      // no 5s left: 7 -> 2,2,2,1
      do_reset();
      for (int k = 0; k < 20; k++) run_payout(5, 0);
      run_payout(7, 0);

      // drain everything, then only two 1s: 5 -> 1,1 short 3
      do_reset();
      run_payout(53760, 0);
      do_refill(0, 2);
      run_payout(5, 1);
      check_stock("stock_after_drain");

      // asynchronous reset during EJECT of a 500
      do_reset();
      bus.change_ready = 1'b0;
      @(negedge clk);
      bus.change_amount = 16'd500;
      bus.change_ready  = 1'b1;
      ej = 0;
      for (int i = 0; i < 10 && bus.coin_eject == 0; i++) @(negedge clk);
      check("eject_500", bus.coin_eject, 9'h080);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_coin_eject", bus.coin_eject, 0);
      check("async_rst_busy", bus.busy, 0);
      model_reset();
      check_stock("stock_after_async_rst");
      bus.change_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ack never comes: timeout, fault, shortfall 10
      @(negedge clk);
      bus.change_amount = 16'd10;
      bus.change_ready  = 1'b1;
      done_seen = 1'b0;
      for (int cyc = 0; cyc < 1000 && !done_seen; cyc++) begin
         @(negedge clk);
         if (bus.payout_done) begin
            done_seen = 1'b1;
            check("fault_at_done", bus.fault, 1);
         end else if (bus.coin_eject != 0) begin
            if (ej == 0) check("timeout_coin", bus.coin_eject, 9'h008);
            if (ej == TMO - 1) check("no_fault_before_timeout", bus.fault, 0);
            ej++;
         end
      end
      check("timeout_done_seen", done_seen, 1);
      check("timeout_eject_cycles", ej, TMO);
      check("timeout_shortfall", bus.shortfall, 10);
      check("timeout_short_flag", bus.short_flag, 1);
      check_stock("stock_after_timeout");

      // edge ignored while faulted
      bus.change_ready = 1'b0;
      @(negedge clk);
      bus.change_ready = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.busy || bus.coin_eject != 0 || bus.payout_done) quiet = 1'b0;
      end
      check("faulted_edge_ignored", quiet, 1);
      check("fault_sticky", bus.fault, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
